// File: rtl/i2c_instr_sequencer.sv
// i2c_instr_sequencer: walks the register memory from address 0 to END_ADDR,
// turning each 32-bit instruction word into one I2C master command.
module i2c_instr_sequencer #(
    parameter int          ADDR_WIDTH     = 8,
    parameter int unsigned END_ADDR       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_data,
    input  logic [3:0]            mem_err,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_rw,
    output logic [6:0]            cmd_dev,
    output logic [7:0]            cmd_reg,
    output logic [7:0]            cmd_wdata,
    input  logic                  i2c_done,
    input  logic                  i2c_nack,
    input  logic [7:0]            i2c_rdata,
    output logic                  rd_valid,
    output logic [7:0]            rd_reg,
    output logic [7:0]            rd_data,
    output logic                  busy,
    output logic                  run_done,
    output logic                  fault,
    output logic [2:0]            fault_code
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] LP_END = ADDR_WIDTH'(END_ADDR);
    localparam logic [TW-1:0] LP_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_DECODE,
        S_ISSUE, S_WAIT, S_NEXT, S_FAULT
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [2:0]              w_fcode;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]              r_op;
    logic [6:0]              r_dev;
    logic [7:0]              r_reg;
    logic [7:0]              r_data;
    logic [3:0]              r_err;
    logic [TW-1:0]           r_tmo;
    logic                    r_rd_valid;
    logic [7:0]              r_rd_reg;
    logic [7:0]              r_rd_data;
    logic                    r_run_done;
    logic [2:0]              r_fcode;
    logic                    w_rd;
    logic                    w_timeout;

    assign w_rd       = (r_op == 8'h01);
    assign w_timeout  = (r_tmo >= LP_TMO_LAST);
    assign mem_addr   = r_addr;
    assign rd_valid   = r_rd_valid;
    assign rd_reg     = r_rd_reg;
    assign rd_data    = r_rd_data;
    assign run_done   = r_run_done;
    assign fault_code = r_fcode;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state, plus the fault code to latch when entering FAULT
    always_comb begin
        w_next  = r_state;
        w_fcode = 3'd0;
        case (r_state)
            S_IDLE:   if (start) w_next = S_FETCH;
            S_FETCH:  w_next = S_LATCH;
            S_LATCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (r_err != 4'd0) begin
                    w_next  = S_FAULT;
                    w_fcode = 3'd1;
                end else if (r_op == 8'h00) begin
                    w_next = S_NEXT;
                end else if (r_op == 8'h01 || r_op == 8'h02) begin
                    w_next = S_ISSUE;
                end else begin
                    w_next  = S_FAULT;
                    w_fcode = 3'd2;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    w_next = S_WAIT;
                end else if (w_timeout) begin
                    w_next  = S_FAULT;
                    w_fcode = 3'd4;
                end
            end
            S_WAIT: begin
                if (i2c_done) begin
                    if (i2c_nack) begin
                        w_next  = S_FAULT;
                        w_fcode = 3'd3;
                    end else begin
                        w_next = S_NEXT;
                    end
                end else if (w_timeout) begin
                    w_next  = S_FAULT;
                    w_fcode = 3'd4;
                end
            end
            S_NEXT:   w_next = (r_addr == LP_END) ? S_IDLE : S_FETCH;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs; the command fields are only driven while issuing
    always_comb begin
        cmd_valid = 1'b0;
        cmd_rw    = 1'b0;
        cmd_dev   = 7'd0;
        cmd_reg   = 8'd0;
        cmd_wdata = 8'd0;
        busy      = 1'b1;
        fault     = 1'b0;
        case (r_state)
            S_ISSUE: begin
                cmd_valid = 1'b1;
                cmd_rw    = w_rd;
                cmd_dev   = r_dev;
                cmd_reg   = r_reg;
                cmd_wdata = w_rd ? 8'd0 : r_data;
            end
            S_IDLE:  busy = 1'b0;
            S_FAULT: begin
                busy  = 1'b0;
                fault = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: address walk, instruction capture, timeout and result pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_op       <= 8'd0;
            r_dev      <= 7'd0;
            r_reg      <= 8'd0;
            r_data     <= 8'd0;
            r_err      <= 4'd0;
            r_tmo      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_reg   <= 8'd0;
            r_rd_data  <= 8'd0;
            r_run_done <= 1'b0;
            r_fcode    <= 3'd0;
        end else begin
            r_rd_valid <= 1'b0;
            r_run_done <= 1'b0;
            if (r_state != S_FAULT && w_next == S_FAULT)
                r_fcode <= w_fcode;
            case (r_state)
                S_IDLE:   if (start) r_addr <= '0;
                S_LATCH: begin
                    r_op   <= mem_data[31:24];
                    r_dev  <= mem_data[22:16];
                    r_reg  <= mem_data[15:8];
                    r_data <= mem_data[7:0];
                    r_err  <= mem_err;
                end
                S_DECODE: r_tmo <= '0;
                S_ISSUE:  r_tmo <= r_tmo + TW'(1);
                S_WAIT: begin
                    r_tmo <= r_tmo + TW'(1);
                    if (i2c_done && !i2c_nack && w_rd) begin
                        r_rd_valid <= 1'b1;
                        r_rd_reg   <= r_reg;
                        r_rd_data  <= i2c_rdata;
                    end
                end
                S_NEXT: begin
                    if (r_addr == LP_END) r_run_done <= 1'b1;
                    else                  r_addr <= r_addr + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_instr_sequencer.sv
// Testbench for i2c_instr_sequencer: directed scenarios plus randomized
// two-word programs checked against a program-level reference model.
module tb_i2c_instr_sequencer;
    localparam int AW    = 8;
    localparam int END_A = 1;
    localparam int TMO   = 4095;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic [3:0]    mem_err;
    logic          cmd_valid, cmd_ready, cmd_rw;
    logic [6:0]    cmd_dev;
    logic [7:0]    cmd_reg, cmd_wdata;
    logic          i2c_done, i2c_nack;
    logic [7:0]    i2c_rdata;
    logic          rd_valid;
    logic [7:0]    rd_reg, rd_data;
    logic          busy, run_done, fault;
    logic [2:0]    fault_code;

    i2c_instr_sequencer #(
        .ADDR_WIDTH(AW), .END_ADDR(END_A), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_err(mem_err),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .i2c_done(i2c_done), .i2c_nack(i2c_nack), .i2c_rdata(i2c_rdata),
        .rd_valid(rd_valid), .rd_reg(rd_reg), .rd_data(rd_data),
        .busy(busy), .run_done(run_done), .fault(fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    // Register memory: word registered one cycle after the address
    logic [31:0] mem  [0:255];
    logic [3:0]  errm [0:255];
    always @(posedge clk) begin
        mem_data <= mem[mem_addr];
        mem_err  <= errm[mem_addr];
    end

    int tests = 0;
    int fails = 0;

    logic [23:0] obs_cmd[$];
    logic [23:0] exp_cmd[$];
    logic [15:0] obs_rd[$];
    logic [15:0] exp_rd[$];
    int obs_done, obs_fcode, obs_faddr, done_cyc, first_wait, valid_cycles;
    int exp_done, exp_fcode, exp_faddr;
    bit stable_ok, timed_out;
    logic [7:0] rdata_tab [0:15];
    int nack_idx;

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        cmd_ready = 1'b0;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        i2c_rdata = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 32'd0;
            errm[i] = 4'd0;
        end
        for (int i = 0; i < 16; i++) rdata_tab[i] = 8'd0;
        nack_idx = -1;
    endtask

    // Starts a run and plays the I2C master until run_done, fault or budget
    task automatic run_prog(input int rdy_dly, input int done_dly,
                            input int max_cyc);
        int vcnt, dcnt, ci;
        bit pend;
        logic [23:0] held, cur;
        vcnt = 0; dcnt = 0; ci = 0; pend = 0; held = '0;
        obs_cmd.delete();
        obs_rd.delete();
        obs_done = 0; obs_fcode = 0; obs_faddr = -1;
        done_cyc = -1; first_wait = -1; valid_cycles = 0;
        stable_ok = 1; timed_out = 1;
        start = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            start = 1'b0;
            cmd_ready = 1'b0;
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            i2c_rdata = 8'd0;
            if (rd_valid) obs_rd.push_back({rd_reg, rd_data});
            if (fault) begin
                obs_fcode = int'(fault_code);
                obs_faddr = int'(mem_addr);
                timed_out = 0;
                break;
            end
            if (run_done) begin
                obs_done++;
                done_cyc = c;
                timed_out = 0;
                break;
            end
            if (pend) begin
                if (dcnt == 0) begin
                    i2c_done = 1'b1;
                    i2c_nack = (ci - 1 == nack_idx);
                    i2c_rdata = rdata_tab[ci-1];
                    pend = 0;
                end else begin
                    dcnt--;
                end
            end
            if (cmd_valid) begin
                valid_cycles++;
                cur = {cmd_rw, cmd_dev, cmd_reg, cmd_wdata};
                if (vcnt == 0) held = cur;
                else if (cur !== held) stable_ok = 0;
                if (vcnt >= rdy_dly) begin
                    cmd_ready = 1'b1;
                    obs_cmd.push_back(cur);
                    if (ci == 0) first_wait = vcnt + 1;
                    ci++;
                    pend = 1;
                    dcnt = done_dly;
                    vcnt = 0;
                end else begin
                    vcnt++;
                end
            end
        end
    endtask

    // Reference model: walks the program by the instruction-set rules
    task automatic model();
        int ci;
        logic [31:0] w;
        logic rw;
        ci = 0;
        exp_cmd.delete();
        exp_rd.delete();
        exp_done = 0; exp_fcode = 0; exp_faddr = -1;
        for (int a = 0; a < 256; a++) begin
            w = mem[a];
            if (errm[a] != 4'd0) begin
                exp_fcode = 1; exp_faddr = a; return;
            end
            if (w[31:24] == 8'd1 || w[31:24] == 8'd2) begin
                rw = (w[31:24] == 8'd1);
                exp_cmd.push_back({rw, w[22:16], w[15:8],
                                   rw ? 8'h00 : w[7:0]});
                if (ci == nack_idx) begin
                    exp_fcode = 3; exp_faddr = a; return;
                end
                if (rw) exp_rd.push_back({w[15:8], rdata_tab[ci]});
                ci++;
            end else if (w[31:24] != 8'd0) begin
                exp_fcode = 2; exp_faddr = a; return;
            end
            if (a == END_A) begin
                exp_done = 1; return;
            end
        end
    endtask

    function automatic logic [55:0] all_outs();
        return {mem_addr, cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata,
                rd_valid, rd_reg, rd_data, busy, run_done, fault, fault_code};
    endfunction

    task automatic test_reset();
        logic [55:0] o;
        clear_mem();
        do_reset();
        @(negedge clk);
        o = all_outs();
        tests++;
        if (o !== 56'd0) begin
            fails++; $display("FAIL reset_outs: got %0h want 0", o);
        end
        i2c_done = 1'b1;
        i2c_rdata = 8'hAA;
        @(negedge clk);
        i2c_done = 1'b0;
        @(negedge clk);
        o = all_outs();
        tests++;
        if (o !== 56'd0) begin
            fails++; $display("FAIL idle_done_ignored: got %0h want 0", o);
        end
    endtask

    task automatic test_program();
        clear_mem();
        do_reset();
        mem[0] = 32'h0100f000;
        mem[1] = 32'h021dab32;
        rdata_tab[0] = 8'h5A;
        run_prog(0, 2, 200);
        tests++;
        if (obs_done !== 1 || timed_out) begin
            fails++; $display("FAIL prog_done: got %0d want 1", obs_done);
        end
        tests++;
        if (obs_cmd.size() != 2) begin
            fails++; $display("FAIL prog_ncmd: got %0d want 2", obs_cmd.size());
        end else begin
            tests++;
            if (obs_cmd[0] !== 24'h80f000) begin
                fails++; $display("FAIL prog_cmd1: got %h want 80f000", obs_cmd[0]);
            end
            tests++;
            if (obs_cmd[1] !== 24'h1dab32) begin
                fails++; $display("FAIL prog_cmd2: got %h want 1dab32", obs_cmd[1]);
            end
        end
        tests++;
        if (obs_rd.size() != 1) begin
            fails++; $display("FAIL prog_nrd: got %0d want 1", obs_rd.size());
        end else begin
            tests++;
            if (obs_rd[0] !== 16'hf05a) begin
                fails++; $display("FAIL prog_rd: got %h want f05a", obs_rd[0]);
            end
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || run_done !== 1'b0) begin
            fails++; $display("FAIL prog_idle: busy %b run_done %b want 0 0", busy, run_done);
        end
    endtask

    task automatic test_nop_latency();
        clear_mem();
        run_prog(0, 0, 100);
        tests++;
        if (done_cyc != 1 + 4 * (END_A + 1)) begin
            fails++; $display("FAIL nop_latency: got %0d want %0d", done_cyc, 1 + 4 * (END_A + 1));
        end
    endtask

    task automatic test_mem_err();
        clear_mem();
        mem[0] = 32'h0100f000;
        mem[1] = 32'h02112233;
        errm[1] = 4'd1;
        run_prog(0, 1, 200);
        tests++;
        if (obs_fcode != 1 || obs_faddr != 1) begin
            fails++; $display("FAIL mem_err: got code %0d addr %0d want 1 1", obs_fcode, obs_faddr);
        end
        tests++;
        if (obs_cmd.size() != 1) begin
            fails++; $display("FAIL mem_err_ncmd: got %0d want 1", obs_cmd.size());
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (fault !== 1'b1 || fault_code !== 3'd1 || mem_addr !== 8'd1 || busy !== 1'b0) begin
            fails++; $display("FAIL fault_sticky: got f%b c%0d a%0d b%b want 1 1 1 0", fault, fault_code, mem_addr, busy);
        end
    endtask

    task automatic test_illegal_and_nack();
        clear_mem();
        do_reset();
        mem[0] = 32'h07000000;
        run_prog(0, 0, 100);
        tests++;
        if (obs_fcode != 2 || obs_faddr != 0 || obs_cmd.size() != 0) begin
            fails++; $display("FAIL illegal: got code %0d addr %0d ncmd %0d want 2 0 0", obs_fcode, obs_faddr, obs_cmd.size());
        end
        clear_mem();
        do_reset();
        mem[0] = 32'h0100f000;
        nack_idx = 0;
        run_prog(0, 3, 100);
        tests++;
        if (obs_fcode != 3 || obs_faddr != 0 || obs_rd.size() != 0) begin
            fails++; $display("FAIL nack: got code %0d addr %0d nrd %0d want 3 0 0", obs_fcode, obs_faddr, obs_rd.size());
        end
    endtask

    task automatic test_stall();
        clear_mem();
        do_reset();
        mem[0] = 32'h0288c3e1;
        run_prog(10, 1, 200);
        tests++;
        if (first_wait != 11 || stable_ok != 1) begin
            fails++; $display("FAIL stall: got accept_cycle %0d stable %0d want 11 1", first_wait, stable_ok);
        end
        tests++;
        if (obs_done != 1 || obs_cmd.size() != 1) begin
            fails++; $display("FAIL stall_done: got done %0d ncmd %0d want 1 1", obs_done, obs_cmd.size());
        end
    endtask

    task automatic test_timeout();
        clear_mem();
        do_reset();
        mem[1] = 32'h01204400;
        run_prog(1 << 30, 0, TMO + 200);
        tests++;
        if (obs_fcode != 4 || obs_faddr != 1) begin
            fails++; $display("FAIL timeout: got code %0d addr %0d want 4 1", obs_fcode, obs_faddr);
        end
        tests++;
        if (valid_cycles != TMO || cmd_valid !== 1'b0) begin
            fails++; $display("FAIL timeout_len: got %0d valid %b want %0d 0", valid_cycles, cmd_valid, TMO);
        end
    endtask

    task automatic test_reset_midop();
        logic [55:0] o;
        int k;
        clear_mem();
        do_reset();
        mem[0] = 32'h0100f000;
        mem[1] = 32'h021dab32;
        rdata_tab[0] = 8'h5A;
        start = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            k++;
        end while (!cmd_valid && k < 50);
        tests++;
        if (!cmd_valid) begin
            fails++; $display("FAIL midop_issue: got valid 0 want 1");
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        o = all_outs();
        tests++;
        if (o !== 56'd0) begin
            fails++; $display("FAIL midop_reset: got %0h want 0", o);
        end
        run_prog(0, 0, 200);
        tests++;
        if (obs_done != 1 || obs_cmd.size() != 2 || obs_cmd[0] !== 24'h80f000) begin
            fails++; $display("FAIL rerun: got done %0d ncmd %0d want 1 2", obs_done, obs_cmd.size());
        end
    endtask

    task automatic test_random();
        int r;
        logic [7:0] op;
        clear_mem();
        do_reset();
        for (int it = 0; it < 30; it++) begin
            for (int a = 0; a <= END_A; a++) begin
                r = $urandom_range(0, 9);
                if (r < 3)      op = 8'h00;
                else if (r < 6) op = 8'h01;
                else if (r < 9) op = 8'h02;
                else            op = 8'($urandom_range(3, 255));
                mem[a]  = {op, 24'($urandom)};
                errm[a] = ($urandom_range(0, 9) == 0) ?
                          4'($urandom_range(1, 15)) : 4'd0;
            end
            for (int i = 0; i < 16; i++) rdata_tab[i] = 8'($urandom);
            nack_idx = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 1) : -1;
            model();
            run_prog($urandom_range(0, 3), $urandom_range(0, 4), 300);
            tests++;
            if (timed_out || obs_fcode != exp_fcode || obs_faddr != exp_faddr || obs_done != exp_done) begin
                fails++;
                $display("FAIL rand%0d_end: got code %0d addr %0d done %0d want %0d %0d %0d",
                         it, obs_fcode, obs_faddr, obs_done, exp_fcode, exp_faddr, exp_done);
            end
            tests++;
            if (obs_cmd.size() != exp_cmd.size()) begin
                fails++; $display("FAIL rand%0d_ncmd: got %0d want %0d", it, obs_cmd.size(), exp_cmd.size());
            end else begin
                for (int i = 0; i < exp_cmd.size(); i++) begin
                    tests++;
                    if (obs_cmd[i] !== exp_cmd[i]) begin
                        fails++; $display("FAIL rand%0d_cmd%0d: got %h want %h", it, i, obs_cmd[i], exp_cmd[i]);
                    end
                end
            end
            tests++;
            if (obs_rd.size() != exp_rd.size()) begin
                fails++; $display("FAIL rand%0d_nrd: got %0d want %0d", it, obs_rd.size(), exp_rd.size());
            end else begin
                for (int i = 0; i < exp_rd.size(); i++) begin
                    tests++;
                    if (obs_rd[i] !== exp_rd[i]) begin
                        fails++; $display("FAIL rand%0d_rd%0d: got %h want %h", it, i, obs_rd[i], exp_rd[i]);
                    end
                end
            end
            if (obs_fcode != 0 || timed_out) do_reset();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        cmd_ready = 1'b0;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        i2c_rdata = 8'd0;
        test_reset();
        test_program();
        test_nop_latency();
        test_mem_err();
        test_illegal_and_nack();
        test_stall();
        test_timeout();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
